// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared types and encodings for the multi-cycle MIPS controller
// Contents: FSM state enum, ALU operation classes, opcode/funct constants,
// ALU-op codes, datapath mux-select codes, trap-cause codes.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_R_WB,
        S_EXEC_I,
        S_I_WB,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR,
        S_TRAP
    } state_t;

    // What the ALU is being asked to do this cycle; FUNCT defers to IR[5:0].
    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_SUB,
        ALU_CLS_SLT,
        ALU_CLS_FUNCT
    } alu_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_REG    = 2'b11;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_BUS     = 2'b10;

    // States that talk to memory and therefore wait on ready / count toward timeout.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mips_mc_alu_decoder.sv
// rtl/mips_mc_alu_decoder.sv - maps ALU op class and funct field to alu_ctrl
// Ports: alu_class (in, op class), funct (in, IR[5:0]),
//        alu_ctrl (out, 3-bit ALU op), illegal (out, unsupported funct for R-type).
module mips_mc_alu_decoder
    import mips_mc_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_ctrl,
    output logic        illegal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (alu_class)
            ALU_CLS_SUB: alu_ctrl = ALU_SUB;
            ALU_CLS_SLT: alu_ctrl = ALU_SLT;
            ALU_CLS_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    FN_JR:   alu_ctrl = ALU_ADD; // jr is legal but uses no ALU op
                    default: illegal  = 1'b1;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multi_cycle_controller.sv
// rtl/mips_multi_cycle_controller.sv - multi-cycle MIPS control FSM with wait states and traps
// Ports: clk, rst (async active-high); opcode/funct (IR fields); zero (ALU flag);
//        mem_ready (memory handshake); datapath controls pc_en, iord, mem_read,
//        mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
//        alu_ctrl, pc_src; status instr_done, trap, trap_cause.
module mips_multi_cycle_controller
    import mips_mc_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int MEM_TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  pc_src,
    output logic        instr_done,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    state_t     state, state_next;
    logic [1:0] cause_q, cause_next;
    logic [WCW-1:0] wait_cnt;

    logic       rdy;
    logic       timeout;
    alu_class_t alu_class;
    logic [2:0] dec_alu_ctrl;
    logic       dec_illegal;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;

    assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // Expires on the wait cycle that would bring the count to MEM_TIMEOUT;
    // a ready in that same cycle still completes the access.
    assign timeout = is_mem_state(state) && !rdy &&
                     (wait_cnt == WCW'(MEM_TIMEOUT - 1));

    always_comb begin
        alu_class = ALU_CLS_ADD;
        case (state)
            S_EXEC_R: alu_class = ALU_CLS_FUNCT;
            S_BRANCH: alu_class = ALU_CLS_SUB;
            S_EXEC_I: alu_class = (opcode == OP_SLTI) ? ALU_CLS_SLT : ALU_CLS_ADD;
            default:  alu_class = ALU_CLS_ADD;
        endcase
    end

    mips_mc_alu_decoder u_alu_decoder (
        .alu_class (alu_class),
        .funct     (funct),
        .alu_ctrl  (dec_alu_ctrl),
        .illegal   (dec_illegal)
    );

    // State register, trap cause and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            cause_q  <= TRAP_NONE;
            wait_cnt <= '0;
        end else begin
            state   <= state_next;
            cause_q <= cause_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (is_mem_state(state) && !rdy)
                wait_cnt <= wait_cnt + WCW'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        cause_next = cause_q;
        case (state)
            S_FETCH: begin
                if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = TRAP_BUS;
                end else if (rdy) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:       state_next = S_EXEC_R;
                    OP_LW, OP_SW:   state_next = S_MEM_ADR;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_ADDI, OP_SLTI: state_next = S_EXEC_I;
                    OP_J:           state_next = S_JUMP;
                    OP_JAL:         state_next = S_JAL;
                    default: begin
                        state_next = S_TRAP;
                        cause_next = TRAP_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R: begin
                if (funct == FN_JR) begin
                    state_next = S_JR;
                end else if (dec_illegal) begin
                    state_next = S_TRAP;
                    cause_next = TRAP_ILLEGAL;
                end else begin
                    state_next = S_R_WB;
                end
            end
            S_EXEC_I:  state_next = S_I_WB;
            S_MEM_ADR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = TRAP_BUS;
                end else if (rdy) begin
                    state_next = S_MEM_WB;
                end
            end
            S_MEM_WR: begin
                if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = TRAP_BUS;
                end else if (rdy) begin
                    state_next = S_FETCH;
                end
            end
            S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                state_next = S_FETCH;
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    // Output decode; everything is forced low while reset is asserted so an
    // in-flight memory strobe drops without waiting for a clock.
    always_comb begin
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = REG_DST_RT;
        mem_to_reg    = M2R_ALUOUT;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        alu_ctrl      = dec_alu_ctrl;
        pc_src        = PC_SRC_ALU;
        instr_done    = 1'b0;
        trap          = 1'b0;
        trap_cause    = cause_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = rdy;
                pc_write  = rdy;
            end
            S_DECODE: alu_src_b = SRC_B_IMM_SH;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_REG;
            end
            S_R_WB: begin
                reg_dst    = REG_DST_RD;
                mem_to_reg = M2R_ALUOUT;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC_I, S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            S_I_WB: begin
                reg_dst    = REG_DST_RT;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_dst    = REG_DST_RT;
                mem_to_reg = M2R_MDR;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = rdy;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRC_B_REG;
                pc_write_cond = 1'b1;
                pc_src        = PC_SRC_ALUOUT;
                branch_ne     = (opcode == OP_BNE);
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_src     = PC_SRC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                // PC+4 is still in the PC here; it is written to r31 on the
                // same edge that loads the jump target.
                pc_src     = PC_SRC_JUMP;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = REG_DST_RA;
                mem_to_reg = M2R_PC;
                instr_done = 1'b1;
            end
            S_JR: begin
                pc_src     = PC_SRC_REG;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: trap = 1'b0;
        endcase

        pc_en = pc_write | (pc_write_cond & (zero ^ branch_ne));

        if (rst) begin
            pc_en      = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 2'b00;
            mem_to_reg = 2'b00;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_ctrl   = 3'b000;
            pc_src     = 2'b00;
            instr_done = 1'b0;
            trap       = 1'b0;
            trap_cause = 2'b00;
        end
    end

endmodule

// File: tb/tb_mips_multi_cycle_controller.sv
// tb/tb_mips_multi_cycle_controller.sv - randomized self-checking bench for the multi-cycle controller
module tb_mips_multi_cycle_controller;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a;
    logic       instr_done, trap;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src, trap_cause;
    logic [2:0] alu_ctrl;

    always #5 clk = ~clk;

    mips_multi_cycle_controller #(.MEM_HANDSHAKE(1), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
        .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause)
    );

    typedef struct packed {
        logic       pc_en, iord, mem_read, mem_write, ir_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic       instr_done, trap;
        logic [1:0] trap_cause;
    } ow_t;

    ow_t obs;
    assign obs = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, instr_done,
                  trap, trap_cause};

    typedef struct {
        logic  rdy;
        ow_t   exp;
        string tag;
    } cyc_t;

    cyc_t plan[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ow_t base();
        ow_t o = '0;
        o.alu_ctrl = 3'b010;
        return o;
    endfunction

    task automatic push(input logic rdy, input ow_t o, input string tag);
        cyc_t c;
        c.rdy = rdy;
        c.exp = o;
        c.tag = tag;
        plan.push_back(c);
    endtask

    task automatic push_trap(input logic [1:0] cause, input int n);
        ow_t o = base();
        o.trap       = 1'b1;
        o.trap_cause = cause;
        for (int i = 0; i < n; i++) push(1'($urandom_range(0, 1)), o, "trap_hold");
    endtask

    // kind: 0 = instruction fetch, 1 = data read, 2 = data write
    task automatic access(input int waits, input int kind, output bit timed_out);
        ow_t o = base();
        o.mem_read  = (kind != 2);
        o.mem_write = (kind == 2);
        o.iord      = (kind != 0);
        if (kind == 0) o.alu_src_b = 2'b01;
        for (int w = 0; w < waits && w < TO; w++) push(1'b0, o, "mem_wait");
        timed_out = (waits >= TO);
        if (!timed_out) begin
            if (kind == 0) begin
                o.ir_write = 1'b1;
                o.pc_en    = 1'b1;
            end
            if (kind == 2) o.instr_done = 1'b1;
            push(1'b1, o, (kind == 0) ? "fetch" : "mem_xfer");
        end
    endtask

    // Instruction-level reference: cycle-by-cycle expected controls.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int wf, input int wm, output bit trapped);
        ow_t o;
        bit  t;
        trapped = 1'b0;
        access(wf, 0, t);
        if (t) begin push_trap(2'b10, 3); trapped = 1'b1; return; end
        o = base(); o.alu_src_b = 2'b11;
        push(1'($urandom_range(0, 1)), o, "decode");
        case (op)
            6'b000000: begin
                logic [2:0] a;
                bit ok = 1'b1;
                case (fn)
                    6'b100000: a = 3'b010;
                    6'b100010: a = 3'b110;
                    6'b100100: a = 3'b000;
                    6'b100101: a = 3'b001;
                    6'b101010: a = 3'b111;
                    default: begin a = 3'b010; ok = (fn == 6'b001000); end
                endcase
                o = base(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b00; o.alu_ctrl = a;
                push(1'($urandom_range(0, 1)), o, "exec_r");
                o = base();
                if (fn == 6'b001000) begin
                    o.pc_src = 2'b11; o.pc_en = 1'b1; o.instr_done = 1'b1;
                    push(1'($urandom_range(0, 1)), o, "jr");
                end else if (ok) begin
                    o.reg_dst = 2'b01; o.reg_write = 1'b1; o.instr_done = 1'b1;
                    push(1'($urandom_range(0, 1)), o, "r_wb");
                end else begin
                    push_trap(2'b01, 3); trapped = 1'b1;
                end
            end
            6'b100011, 6'b101011: begin
                o = base(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                push(1'($urandom_range(0, 1)), o, "mem_adr");
                access(wm, (op == 6'b100011) ? 1 : 2, t);
                if (t) begin
                    push_trap(2'b10, 3); trapped = 1'b1;
                end else if (op == 6'b100011) begin
                    o = base(); o.mem_to_reg = 2'b01; o.reg_write = 1'b1; o.instr_done = 1'b1;
                    push(1'($urandom_range(0, 1)), o, "mem_wb");
                end
            end
            6'b000100, 6'b000101: begin
                o = base(); o.alu_src_a = 1'b1; o.alu_ctrl = 3'b110; o.pc_src = 2'b01;
                o.pc_en = z ^ (op == 6'b000101); o.instr_done = 1'b1;
                push(1'($urandom_range(0, 1)), o, "branch");
            end
            6'b001000, 6'b001010: begin
                o = base(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                o.alu_ctrl = (op == 6'b001010) ? 3'b111 : 3'b010;
                push(1'($urandom_range(0, 1)), o, "exec_i");
                o = base(); o.reg_write = 1'b1; o.instr_done = 1'b1;
                push(1'($urandom_range(0, 1)), o, "i_wb");
            end
            6'b000010: begin
                o = base(); o.pc_src = 2'b10; o.pc_en = 1'b1; o.instr_done = 1'b1;
                push(1'($urandom_range(0, 1)), o, "jump");
            end
            6'b000011: begin
                o = base(); o.pc_src = 2'b10; o.pc_en = 1'b1; o.reg_write = 1'b1;
                o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; o.instr_done = 1'b1;
                push(1'($urandom_range(0, 1)), o, "jal");
            end
            default: begin
                push_trap(2'b01, 3); trapped = 1'b1;
            end
        endcase
    endtask

    // Called and returns at posedge+1.
    task automatic do_reset();
        rst = 1'b1;
        #1 check("rst_outputs", obs, 0);
        @(posedge clk);
        #1 check("rst_held", obs, 0);
        rst = 1'b0;
    endtask

    task automatic run_plan(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input bit abort_on_write, output bit aborted);
        aborted = 1'b0;
        foreach (plan[i]) begin
            opcode = op; funct = fn; zero = z; mem_ready = plan[i].rdy;
            @(negedge clk);
            check(plan[i].tag, obs, plan[i].exp);
            if (abort_on_write && plan[i].exp.mem_write) begin
                #2 rst = 1'b1;
                #1;
                check("rst_mid_wr_mem_write", mem_write, 0);
                check("rst_mid_wr_outputs", obs, 0);
                @(posedge clk);
                #1 rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wf, input int wm, input bit abort_on_write);
        bit t, ab;
        plan.delete();
        build(op, fn, z, wf, wm, t);
        run_plan(op, fn, z, abort_on_write, ab);
        if (t && !ab) do_reset();
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 9))
            0: return 6'b000000;
            1: return 6'b100011;
            2: return 6'b101011;
            3: return 6'b000100;
            4: return 6'b000101;
            5: return 6'b001000;
            6: return 6'b001010;
            7: return 6'b000010;
            8: return 6'b000011;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    function automatic logic [5:0] pick_fn();
        case ($urandom_range(0, 6))
            0: return 6'b100000;
            1: return 6'b100010;
            2: return 6'b100100;
            3: return 6'b100101;
            4: return 6'b101010;
            5: return 6'b001000;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    function automatic int pick_waits();
        int r = $urandom_range(0, 19);
        if (r < 12) return 0;
        if (r < 16) return $urandom_range(1, 2);
        if (r < 18) return 3;
        return $urandom_range(4, 5);
    endfunction

    initial begin
        rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        #1 check("reset_outputs", obs, 0);
        @(posedge clk);
        #1 check("reset_outputs_held", obs, 0);
        rst = 1'b0;

        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0);   // add
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 3, 1'b0);   // lw, 3 read waits
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0);   // beq taken
        run_instr(6'b000101, 6'b000000, 1'b1, 0, 0, 1'b0);   // bne not taken
        run_instr(6'b000101, 6'b000000, 1'b0, 0, 0, 1'b0);   // bne taken
        run_instr(6'b000011, 6'b000000, 1'b0, 0, 0, 1'b0);   // jal
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0);   // illegal opcode
        run_instr(6'b000000, 6'b111111, 1'b0, 0, 0, 1'b0);   // illegal funct
        run_instr(6'b000000, 6'b100000, 1'b0, 4, 0, 1'b0);   // fetch timeout
        run_instr(6'b000000, 6'b100010, 1'b0, 3, 0, 1'b0);   // ready on last allowed cycle
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 4, 1'b0);   // read timeout
        run_instr(6'b101011, 6'b000000, 1'b0, 1, 4, 1'b0);   // write timeout
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 2, 1'b1);   // reset during write
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 2, 1'b0);   // sw after reset

        for (int k = 0; k < 200; k++)
            run_instr(pick_op(), pick_fn(), 1'($urandom_range(0, 1)),
                      pick_waits(), pick_waits(), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
